// File: rtl/btn_debounce_array.sv
// Multi-channel push-button conditioner: 2-FF synchroniser, tick-sampled integrator
// debounce, press/release pulses, long-press and auto-repeat pulses per channel.
module btn_debounce_array #(
   parameter int CH           = 4,
   parameter int SAMPLE_DIV   = 100000,
   parameter int STABLE_CNT   = 4,
   parameter int LONG_TICKS   = 1000,
   parameter int REPEAT_TICKS = 200,
   parameter bit ACTIVE_LOW   = 1'b0
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [CH-1:0] btn,
   output logic [CH-1:0] btn_lvl,
   output logic [CH-1:0] btn_pe,
   output logic [CH-1:0] btn_ne,
   output logic [CH-1:0] btn_long,
   output logic [CH-1:0] btn_rpt
);

   localparam int DW = $clog2(SAMPLE_DIV);
   localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
   localparam int HW = $clog2(LONG_TICKS + 1);
   localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

   localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CNT - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
   localparam logic [RW-1:0] RPT_LAST  = (REPEAT_TICKS > 0) ? RW'(REPEAT_TICKS - 1) : '0;

   logic [DW-1:0] div_cnt_r;
   logic          tick_s;
   logic [CH-1:0] sync1_r;
   logic [CH-1:0] sync2_r;
   logic [CH-1:0] samp_s;

   assign tick_s = (div_cnt_r == DIV_LAST);
   assign samp_s = sync2_r ^ {CH{ACTIVE_LOW}};

   // Shared sample-tick divider, wraps at SAMPLE_DIV-1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt_r <= '0;
      end else if (tick_s) begin
         div_cnt_r <= '0;
      end else begin
         div_cnt_r <= div_cnt_r + DW'(1);
      end
   end

   // Two-stage synchroniser for the asynchronous button pins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r <= '0;
         sync2_r <= '0;
      end else begin
         sync1_r <= btn;
         sync2_r <= sync1_r;
      end
   end

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic [CW-1:0] cnt_r;
      logic [CW-1:0] cnt_nxt_s;
      logic          flip_s;
      logic          lvl_r;
      logic          pe_r;
      logic          ne_r;
      logic [HW-1:0] hold_r;
      logic [HW-1:0] hold_nxt_s;
      logic [RW-1:0] rpt_cnt_r;
      logic [RW-1:0] rpt_cnt_nxt_s;
      logic          long_nxt_s;
      logic          rpt_nxt_s;
      logic          long_r;
      logic          rpt_r;

      // Integrator: the level flips only after STABLE_CNT consecutive disagreeing samples.
      always_comb begin
         cnt_nxt_s = cnt_r;
         flip_s    = 1'b0;
         if (tick_s) begin
            if (samp_s[i] == lvl_r) begin
               cnt_nxt_s = '0;
            end else if (cnt_r == CNT_LAST) begin
               cnt_nxt_s = '0;
               flip_s    = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + CW'(1);
            end
         end else begin
            cnt_nxt_s = cnt_r;
         end
      end

      // Hold and repeat: released or releasing channels are cleared so nothing fires late.
      always_comb begin
         hold_nxt_s    = hold_r;
         rpt_cnt_nxt_s = rpt_cnt_r;
         long_nxt_s    = 1'b0;
         rpt_nxt_s     = 1'b0;
         if (!lvl_r || flip_s) begin
            hold_nxt_s    = '0;
            rpt_cnt_nxt_s = '0;
         end else if (tick_s) begin
            if (hold_r != HOLD_MAX) begin
               hold_nxt_s = hold_r + HW'(1);
               long_nxt_s = (hold_r == HOLD_LAST);
            end else if (REPEAT_TICKS > 0) begin
               if (rpt_cnt_r == RPT_LAST) begin
                  rpt_cnt_nxt_s = '0;
                  rpt_nxt_s     = 1'b1;
               end else begin
                  rpt_cnt_nxt_s = rpt_cnt_r + RW'(1);
               end
            end else begin
               rpt_cnt_nxt_s = '0;
            end
         end else begin
            hold_nxt_s = hold_r;
         end
      end

      // Per-channel state and registered pulse outputs.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt_r     <= '0;
            lvl_r     <= 1'b0;
            pe_r      <= 1'b0;
            ne_r      <= 1'b0;
            hold_r    <= '0;
            rpt_cnt_r <= '0;
            long_r    <= 1'b0;
            rpt_r     <= 1'b0;
         end else begin
            cnt_r     <= cnt_nxt_s;
            lvl_r     <= lvl_r ^ flip_s;
            pe_r      <= flip_s & ~lvl_r;
            ne_r      <= flip_s & lvl_r;
            hold_r    <= hold_nxt_s;
            rpt_cnt_r <= rpt_cnt_nxt_s;
            long_r    <= long_nxt_s;
            rpt_r     <= rpt_nxt_s;
         end
      end

      assign btn_lvl[i]  = lvl_r;
      assign btn_pe[i]   = pe_r;
      assign btn_ne[i]   = ne_r;
      assign btn_long[i] = long_r;
      assign btn_rpt[i]  = rpt_r;
   end

endmodule

// File: tb/tb_btn_debounce_array.sv
// Directed bench for btn_debounce_array with SAMPLE_DIV=4, STABLE_CNT=3, LONG_TICKS=5, REPEAT_TICKS=2.
module tb_btn_debounce_array;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] btn;
   logic [3:0] btn_lvl, btn_pe, btn_ne, btn_long, btn_rpt;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int pe_cnt [4];
   int ne_cnt [4];
   int long_cnt [4];
   int rpt_cnt [4];
   int pe0_snap;

   btn_debounce_array #(
      .CH(4), .SAMPLE_DIV(4), .STABLE_CNT(3), .LONG_TICKS(5), .REPEAT_TICKS(2), .ACTIVE_LOW(1'b0)
   ) dut (
      .clk(clk), .reset_n(reset_n), .btn(btn), .btn_lvl(btn_lvl), .btn_pe(btn_pe),
      .btn_ne(btn_ne), .btn_long(btn_long), .btn_rpt(btn_rpt)
   );

   always #5 clk = ~clk;

   // Clock edges since the last reset release; tick edges fall on multiples of 4.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else cyc <= cyc + 1;
   end

   // Pulse tallies, sampled mid-cycle.
   always @(negedge clk) begin
      if (reset_n) begin
         for (int c = 0; c < 4; c++) begin
            pe_cnt[c]   = pe_cnt[c] + int'(btn_pe[c]);
            ne_cnt[c]   = ne_cnt[c] + int'(btn_ne[c]);
            long_cnt[c] = long_cnt[c] + int'(btn_long[c]);
            rpt_cnt[c]  = rpt_cnt[c] + int'(btn_rpt[c]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic goto(input int k);
      while (cyc < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      for (int c = 0; c < 4; c++) begin
         pe_cnt[c] = 0; ne_cnt[c] = 0; long_cnt[c] = 0; rpt_cnt[c] = 0;
      end
      reset_n = 1'b1;
      btn = 4'b0000;
      #1 reset_n = 1'b0;
      #11;
      chk("reset_outs", {12'd0, btn_lvl, btn_pe, btn_ne, btn_long, btn_rpt}, 32'd0);
      #10 reset_n = 1'b1;

      // 1: single press on ch0
      goto(2);  btn[0] = 1'b1;
      goto(15); chk("t1_lvl_before", {28'd0, btn_lvl}, 32'h0);
      goto(16); chk("t1_lvl_rise", {28'd0, btn_lvl}, 32'h1);
                chk("t1_pe", {28'd0, btn_pe}, 32'h1);
      goto(17); chk("t1_pe_one_clk", {28'd0, btn_pe}, 32'h0);
                btn[0] = 1'b0;
      goto(27); chk("t1_lvl_held", {28'd0, btn_lvl}, 32'h1);
      goto(28); chk("t1_ne", {28'd0, btn_ne}, 32'h1);
                chk("t1_lvl_fall", {28'd0, btn_lvl}, 32'h0);

      // 2: bouncing input on ch0, then settles high
      for (int j = 0; j < 10; j++) begin
         goto(30 + 3 * j);
         btn[0] = (j % 2 == 0);
      end
      goto(60); btn[0] = 1'b1;
      goto(71); chk("t2_no_pe_bounce", pe_cnt[0], 32'd1);
                chk("t2_lvl_low", {28'd0, btn_lvl}, 32'h0);
      goto(72); chk("t2_pe_settled", {28'd0, btn_pe}, 32'h1);
      goto(73); chk("t2_pe_total", pe_cnt[0], 32'd2);

      // 3: short glitch on ch2; ch0 keeps holding
      goto(80); btn[2] = 1'b1;
      goto(86); btn[2] = 1'b0;
      goto(91); chk("t3_long0_before", {28'd0, btn_long}, 32'h0);
      goto(92); chk("t3_long0", {28'd0, btn_long}, 32'h1);
      goto(100);
                chk("t3_rpt0", {28'd0, btn_rpt}, 32'h1);
                chk("t3_lvl2_low", {31'd0, btn_lvl[2]}, 32'h0);
                chk("t3_pe_ne2", pe_cnt[2] + ne_cnt[2], 32'd0);
      goto(101); chk("t3_rpt0_one_clk", {28'd0, btn_rpt}, 32'h0);

      // 4: long hold with repeat on ch1, then release
      goto(102); btn[1] = 1'b1;
      goto(116); chk("t4_pe1", {28'd0, btn_pe}, 32'h2);
      goto(135); chk("t4_long_before", {28'd0, btn_long}, 32'h0);
      goto(136); chk("t4_long1", {28'd0, btn_long}, 32'h2);
                 chk("t4_no_rpt_with_long", {28'd0, btn_rpt}, 32'h0);
      goto(144); chk("t4_rpt_first", {28'd0, btn_rpt}, 32'h2);
      goto(152); chk("t4_rpt_second", {28'd0, btn_rpt}, 32'h2);
      goto(182); btn[1] = 1'b0;
      goto(196); chk("t4_ne1", {28'd0, btn_ne}, 32'h2);
                 chk("t4_lvl_after_ne", {28'd0, btn_lvl}, 32'h1);
      goto(220); chk("t4_rpt_total", rpt_cnt[1], 32'd7);
                 chk("t4_long_total", long_cnt[1], 32'd1);
                 chk("t4_ne_total", ne_cnt[1], 32'd1);

      // 5: simultaneous press on ch1 and ch3
      goto(222); btn[1] = 1'b1; btn[3] = 1'b1;
      goto(236); chk("t5_pe_pair", {28'd0, btn_pe}, 32'ha);
                 chk("t5_lvl", {28'd0, btn_lvl}, 32'hb);
      goto(255); chk("t5_long_before", {28'd0, btn_long}, 32'h0);
      goto(256); chk("t5_long_pair", {28'd0, btn_long}, 32'ha);

      // 6: asynchronous reset during a ch0 hold
      goto(260); chk("t6_lvl_pre", {28'd0, btn_lvl}, 32'hb);
      #3 reset_n = 1'b0;
      #1 chk("t6_async_clear", {12'd0, btn_lvl, btn_pe, btn_ne, btn_long, btn_rpt}, 32'd0);
      btn[1] = 1'b0; btn[3] = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("t6_held_in_reset", {28'd0, btn_lvl}, 32'h0);
      #1 reset_n = 1'b1;
      goto(11); chk("t6_lvl_before", {28'd0, btn_lvl}, 32'h0);
      goto(12); chk("t6_pe_fresh", {28'd0, btn_pe}, 32'h1);
                chk("t6_lvl_fresh", {28'd0, btn_lvl}, 32'h1);
      goto(31); chk("t6_long_before", {28'd0, btn_long}, 32'h0);
      goto(32); chk("t6_long", {28'd0, btn_long}, 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
